// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and default frame geometry.
// uart_rx uses them today and uart_tx will reuse them.
package uart_pkg;

  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Output handshake of the UART receiver.
// The receiver is the master (it drives the byte); the consumer is the slave.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun,
    output rx_ready
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input into the clk domain.
// RESET_VAL sets the value both flops hold while in reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make the two flops a real two-stage chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/stop framing timed by ticks derived
// from RXclk, with a one-entry output register and valid/ready handshake.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      RXclk,
  input  logic      rx,
  uart_rx_if.master out
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 rx_s, rxclk_s;
  logic                 rx_prev, rxclk_prev;
  logic [1:0]           settle;
  logic                 settle_done, tick, rx_fall;
  uart_state_e          state;
  logic [CNT_W-1:0]     tick_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync_rx    (.clk(clk), .rst(rst), .d(rx),    .q(rx_s));
  sync_2ff #(.RESET_VAL(1'b0)) u_sync_rxclk (.clk(clk), .rst(rst), .d(RXclk), .q(rxclk_s));

  // The rx synchronizer resets to idle-high, so a line already low at reset
  // exit would look like a falling edge; ignore edges until the chain has flushed.
  assign settle_done = (settle == 2'd3);
  assign tick        = rxclk_s & ~rxclk_prev;
  assign rx_fall     = settle_done & rx_prev & ~rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev    <= 1'b1;
      rxclk_prev <= 1'b0;
      settle     <= 2'd0;
    end else begin
      rx_prev    <= rx_s;
      rxclk_prev <= rxclk_s;
      if (!settle_done) settle <= settle + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      out.rx_data   <= '0;
      out.rx_valid  <= 1'b0;
      out.frame_err <= 1'b0;
      out.overrun   <= 1'b0;
    end else begin
      out.frame_err <= 1'b0;
      out.overrun   <= 1'b0;
      // A completing good frame later in this block overrides this clear.
      if (out.rx_valid && out.rx_ready) out.rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_fall) begin
            tick_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
              if (bit_idx == BIT_LAST) state <= STOP;
              else                     bit_idx <= bit_idx + BIT_W'(1);
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
              if (!rx_s) begin
                out.frame_err <= 1'b1;
              end else if (!out.rx_valid || out.rx_ready) begin
                out.rx_data  <= shreg;
                out.rx_valid <= 1'b1;
              end else begin
                out.overrun <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame scenarios plus randomized
// frames checked against a one-entry output-buffer model.
module tb_uart_rx;

  localparam int CLK_T      = 10;
  localparam int RX_PERIOD  = 4 * CLK_T;
  localparam int OVS        = 16;
  localparam int BIT_T      = OVS * RX_PERIOD;
  // Frame start (aligned to an RXclk rise) to the clk edge that loads rx_data:
  // 23 time units of synchronizer + edge-detect delay, then half a start bit,
  // eight data bits and the stop bit, all counted in RXclk rises.
  localparam int STOP_EDGE  = 23 + (OVS / 2 + 8 * OVS + OVS) * RX_PERIOD;

  logic clk, rst, RXclk, rx;
  int   n_total = 0;
  int   n_pass  = 0;
  int   fe_cnt  = 0;
  int   ov_cnt  = 0;
  logic [7:0] acc_q[$];

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OVS)) dut (
    .clk  (clk),
    .rst  (rst),
    .RXclk(RXclk),
    .rx   (rx),
    .out  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #(CLK_T / 2) clk = ~clk;
  end

  initial begin
    RXclk = 1'b0;
    #2;
    forever #(RX_PERIOD / 2) RXclk = ~RXclk;
  end

  always @(negedge clk) begin
    if (bus.rx_valid && bus.rx_ready) acc_q.push_back(bus.rx_data);
    if (bus.frame_err) fe_cnt++;
    if (bus.overrun)   ov_cnt++;
  end

  task automatic send_frame_now(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(BIT_T);
    end
    rx = stop_bit;
    #(BIT_T);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge RXclk);
    send_frame_now(b, stop_bit);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 bus.rx_ready = v;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx = 1'b1;
    bus.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_total++; if (bus.rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.rx_valid); else n_pass++;
    n_total++; if (bus.rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.rx_data); else n_pass++;
    n_total++; if (bus.frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", bus.frame_err); else n_pass++;
    n_total++; if (bus.overrun !== 1'b0) $display("FAIL reset_ovr: got %b want 0", bus.overrun); else n_pass++;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_basic;
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    acc_q.delete();
    @(posedge RXclk);
    fork
      send_frame_now(8'hA5, 1'b1);
      begin
        #(STOP_EDGE - 5);
        n_total++; if (bus.rx_valid !== 1'b0) $display("FAIL basic_early: rx_valid got %b want 0", bus.rx_valid); else n_pass++;
        #(CLK_T);
        n_total++; if (bus.rx_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", bus.rx_valid); else n_pass++;
        n_total++; if (bus.rx_data !== 8'hA5) $display("FAIL basic_data: got %h want a5", bus.rx_data); else n_pass++;
        #(CLK_T);
        n_total++; if (bus.rx_valid !== 1'b0) $display("FAIL basic_one_clk: rx_valid got %b want 0", bus.rx_valid); else n_pass++;
      end
    join
    #100;
    n_total++; if (fe_cnt - fe0 !== 0) $display("FAIL basic_ferr: pulses %0d want 0", fe_cnt - fe0); else n_pass++;
    n_total++; if (ov_cnt - ov0 !== 0) $display("FAIL basic_ovr: pulses %0d want 0", ov_cnt - ov0); else n_pass++;
    n_total++; if (acc_q.size() !== 1) $display("FAIL basic_count: bytes %0d want 1", acc_q.size()); else n_pass++;
  endtask

  task automatic test_glitch;
    int fe0 = fe_cnt;
    acc_q.delete();
    @(posedge RXclk);
    rx = 1'b0;
    #(3 * RX_PERIOD);
    rx = 1'b1;
    #(2 * BIT_T);
    n_total++; if (acc_q.size() !== 0) $display("FAIL glitch_novalid: bytes %0d want 0", acc_q.size()); else n_pass++;
    n_total++; if (fe_cnt - fe0 !== 0) $display("FAIL glitch_ferr: pulses %0d want 0", fe_cnt - fe0); else n_pass++;
    send_frame(8'h3C, 1'b1);
    #100;
    n_total++;
    if (acc_q.size() !== 1 || acc_q[0] !== 8'h3C)
      $display("FAIL glitch_next: bytes %0d first %h want 1 x 3c", acc_q.size(), acc_q.size() ? acc_q[0] : 8'h00);
    else n_pass++;
  endtask

  task automatic test_frame_err;
    int fe0 = fe_cnt;
    acc_q.delete();
    send_frame(8'h55, 1'b0);
    #(BIT_T);
    n_total++; if (fe_cnt - fe0 !== 1) $display("FAIL ferr_pulse: pulses %0d want 1", fe_cnt - fe0); else n_pass++;
    n_total++; if (acc_q.size() !== 0) $display("FAIL ferr_novalid: bytes %0d want 0", acc_q.size()); else n_pass++;
    n_total++; if (bus.rx_valid !== 1'b0) $display("FAIL ferr_valid: got %b want 0", bus.rx_valid); else n_pass++;
    send_frame(8'h0F, 1'b1);
    #100;
    n_total++;
    if (acc_q.size() !== 1 || acc_q[0] !== 8'h0F)
      $display("FAIL ferr_next: bytes %0d first %h want 1 x 0f", acc_q.size(), acc_q.size() ? acc_q[0] : 8'h00);
    else n_pass++;
  endtask

  task automatic test_overrun;
    int ov0 = ov_cnt;
    acc_q.delete();
    set_ready(1'b0);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    #100;
    n_total++; if (ov_cnt - ov0 !== 1) $display("FAIL ovr_pulse: pulses %0d want 1", ov_cnt - ov0); else n_pass++;
    n_total++; if (bus.rx_valid !== 1'b1) $display("FAIL ovr_valid: got %b want 1", bus.rx_valid); else n_pass++;
    n_total++; if (bus.rx_data !== 8'h11) $display("FAIL ovr_data: got %h want 11", bus.rx_data); else n_pass++;
    set_ready(1'b1);
    set_ready(1'b0);
    @(negedge clk);
    n_total++; if (bus.rx_valid !== 1'b0) $display("FAIL ovr_drain: rx_valid got %b want 0", bus.rx_valid); else n_pass++;
    n_total++;
    if (acc_q.size() !== 1 || acc_q[0] !== 8'h11)
      $display("FAIL ovr_consumed: bytes %0d first %h want 1 x 11", acc_q.size(), acc_q.size() ? acc_q[0] : 8'h00);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int ov0 = ov_cnt;
    acc_q.delete();
    send_frame(8'h66, 1'b1);
    #100;
    n_total++; if (bus.rx_data !== 8'h66) $display("FAIL b2b_hold: got %h want 66", bus.rx_data); else n_pass++;
    @(posedge RXclk);
    fork
      send_frame_now(8'h77, 1'b1);
      begin
        #(STOP_EDGE - 9) bus.rx_ready = 1'b1;
        #(CLK_T)         bus.rx_ready = 1'b0;
      end
    join
    #100;
    n_total++;
    if (acc_q.size() !== 1 || acc_q[0] !== 8'h66)
      $display("FAIL b2b_consumed: bytes %0d first %h want 1 x 66", acc_q.size(), acc_q.size() ? acc_q[0] : 8'h00);
    else n_pass++;
    n_total++; if (bus.rx_data !== 8'h77) $display("FAIL b2b_data: got %h want 77", bus.rx_data); else n_pass++;
    n_total++; if (bus.rx_valid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", bus.rx_valid); else n_pass++;
    n_total++; if (ov_cnt - ov0 !== 0) $display("FAIL b2b_ovr: pulses %0d want 0", ov_cnt - ov0); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    acc_q.delete();
    @(posedge RXclk);
    fork
      send_frame_now(8'hC3, 1'b1);
      begin
        #(84 * RX_PERIOD) rst = 1'b1;
        @(negedge clk);
        n_total++; if (bus.rx_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", bus.rx_valid); else n_pass++;
        n_total++; if (bus.rx_data !== 8'h00) $display("FAIL rstmid_data: got %h want 00", bus.rx_data); else n_pass++;
        n_total++; if (bus.frame_err !== 1'b0) $display("FAIL rstmid_ferr: got %b want 0", bus.frame_err); else n_pass++;
        n_total++; if (bus.overrun !== 1'b0) $display("FAIL rstmid_ovr: got %b want 0", bus.overrun); else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    #(BIT_T);
    n_total++; if (fe_cnt - fe0 !== 0) $display("FAIL rstmid_noferr: pulses %0d want 0", fe_cnt - fe0); else n_pass++;
    n_total++; if (ov_cnt - ov0 !== 0) $display("FAIL rstmid_noovr: pulses %0d want 0", ov_cnt - ov0); else n_pass++;
    n_total++; if (bus.rx_valid !== 1'b0) $display("FAIL rstmid_nostart: rx_valid got %b want 0", bus.rx_valid); else n_pass++;
    set_ready(1'b1);
    send_frame(8'h81, 1'b1);
    #100;
    n_total++;
    if (acc_q.size() !== 1 || acc_q[0] !== 8'h81)
      $display("FAIL rstmid_next: bytes %0d first %h want 1 x 81", acc_q.size(), acc_q.size() ? acc_q[0] : 8'h00);
    else n_pass++;
  endtask

  // Reference model: a one-entry output buffer. Consumer readiness is chosen
  // per frame and held for the whole frame.
  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] held = 8'h00;
    logic [7:0] b;
    bit         full = 1'b0;
    bit         rdy, good;
    int         exp_fe = 0;
    int         exp_ov = 0;
    int         fe0 = fe_cnt;
    int         ov0 = ov_cnt;
    acc_q.delete();
    for (int i = 0; i < 8; i++) begin
      rdy  = 1'($urandom_range(0, 1));
      good = ($urandom_range(0, 3) != 0);
      b    = 8'($urandom_range(0, 255));
      set_ready(rdy);
      if (rdy && full) begin
        exp_q.push_back(held);
        full = 1'b0;
      end
      send_frame(b, good);
      if (!good)      exp_fe++;
      else if (full)  exp_ov++;
      else if (rdy)   exp_q.push_back(b);
      else begin
        held = b;
        full = 1'b1;
      end
      #($urandom_range(0, 300));
    end
    set_ready(1'b1);
    if (full) exp_q.push_back(held);
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_total++; if (acc_q.size() !== exp_q.size()) $display("FAIL rand_count: bytes %0d want %0d", acc_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      n_total++; if (acc_q[i] !== exp_q[i]) $display("FAIL rand_byte%0d: got %h want %h", i, acc_q[i], exp_q[i]); else n_pass++;
    end
    n_total++; if (fe_cnt - fe0 !== exp_fe) $display("FAIL rand_ferr: pulses %0d want %0d", fe_cnt - fe0, exp_fe); else n_pass++;
    n_total++; if (ov_cnt - ov0 !== exp_ov) $display("FAIL rand_ovr: pulses %0d want %0d", ov_cnt - ov0, exp_ov); else n_pass++;
    n_total++; if (bus.rx_valid !== 1'b0) $display("FAIL rand_drained: rx_valid got %b want 0", bus.rx_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
